// File: rtl/subarashii_pkg.sv
// Shared definitions for the register-file debug dump engine: state encoding
// and default geometry of the CPU register file.
package subarashii_pkg;

  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = 4;
  localparam int WORD_W     = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_HALT = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_HALT = ST_WAIT_HALT,
    READ      = ST_READ,
    SEND      = ST_SEND,
    FINISH    = ST_FINISH
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Tagged register-value stream from the dump engine toward the debug link.
interface regfile_dump_if #(
  parameter int ADDR_W = subarashii_pkg::REG_ADDR_W,
  parameter int DATA_W = subarashii_pkg::WORD_W
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/regfile.sv
// 16x16 CPU register file: one synchronous write port, one combinational read
// port. The dump engine borrows the read port while the core is halted.
module regfile
  import subarashii_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] selRa,
  output logic [DATA_W-1:0] ra
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we && (int'(wsel) < NUM_REGS)) regs[wsel] <= wdata;
  end

  assign ra = (int'(selRa) < NUM_REGS) ? regs[selRa] : '0;

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks every register through the debug read port
// while the core is halted and emits each value as a tagged stream word.
//
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_HALT | dump active, core not halted yet
//   READ      | selDbg=idx, sample register on next edge
//   SEND      | word pending on the stream until handshake
//   FINISH    | last word accepted, emit done
module regfile_dump
  import subarashii_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                halted,
  output logic [ADDR_W-1:0]   selDbg,
  input  logic [DATA_W-1:0]   dbgData,
  regfile_dump_if.master      out,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] sel_q;
  logic              kill;
  logic              load;
  logic              hs;

  assign kill = abort && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hs      = 1'b0;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (start) state_d = WAIT_HALT;
        WAIT_HALT: if (halted) state_d = READ;
        READ: begin
          if (halted) begin
            load    = 1'b1;
            state_d = SEND;
          end else begin
            state_d = WAIT_HALT;
          end
        end
        SEND: begin
          if (out.out_valid && out.out_ready) begin
            hs = 1'b1;
            if (idx_q == LAST_IDX) state_d = FINISH;
            else if (halted)       state_d = READ;
            else                   state_d = WAIT_HALT;
          end
        end
        FINISH:    state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Select follows idx only while reading; otherwise it holds its last value.
  assign selDbg = (state_q == READ) ? idx_q : sel_q;
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      sel_q         <= '0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_idx   <= '0;
      done          <= 1'b0;
    end else begin
      sel_q <= selDbg;
      done  <= (state_q == FINISH) && !kill;
      if (kill) begin
        out.out_valid <= 1'b0;
        idx_q         <= '0;
      end else begin
        if ((state_q == IDLE) && start) idx_q <= '0;
        if (load) begin
          out.out_data  <= dbgData;
          out.out_idx   <= idx_q;
          out.out_valid <= 1'b1;
        end
        if (hs) begin
          out.out_valid <= 1'b0;
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
        if (state_q == FINISH) idx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump driving the real regfile read port.
module tb_regfile_dump;
  import subarashii_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, abort, halted;
  logic        we;
  logic [3:0]  wsel;
  logic [15:0] wdata;
  logic [3:0]  selDbg;
  logic [15:0] dbgData;
  logic        busy, done;

  logic        bp_mode = 1'b0;
  logic        ready_lvl = 1'b1;
  int          bp_cnt = 0;

  int checks = 0;
  int errors = 0;
  int nacc = 0;
  int done_cnt = 0;
  logic [19:0] exp_q[$];

  regfile_dump_if #(.ADDR_W(4), .DATA_W(16)) sif ();

  regfile u_rf (
    .clk(clk), .we(we), .wsel(wsel), .wdata(wdata),
    .selRa(selDbg), .ra(dbgData)
  );

  regfile_dump dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .halted(halted),
    .selDbg(selDbg), .dbgData(dbgData), .out(sif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ready driver: constant level or 1-of-3 backpressure pattern.
  always @(posedge clk) begin
    #2;
    if (bp_mode) begin
      sif.out_ready = (bp_cnt % 3 == 0);
      bp_cnt++;
    end else begin
      sif.out_ready = ready_lvl;
    end
  end

  // Monitor: pops the scoreboard on every accepted word, checks hold stability.
  logic        stall = 1'b0;
  logic [15:0] held_data;
  logic [3:0]  held_idx;
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall && sif.out_valid) begin
        chk("hold_data", 32'(sif.out_data), 32'(held_data));
        chk("hold_idx", 32'(sif.out_idx), 32'(held_idx));
      end
      if (sif.out_valid && sif.out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(sif.out_idx), 32'hFFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("word_idx", 32'(sif.out_idx), 32'(e[19:16]));
          chk("word_data", 32'(sif.out_data), 32'(e[15:0]));
        end
        nacc++;
      end
      if (done) done_cnt++;
      stall     = sif.out_valid && !sif.out_ready && !abort;
      held_data = sif.out_data;
      held_idx  = sif.out_idx;
    end
  end

  task automatic push_seq(input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back({4'(i), 16'h0100 + 16'(i)});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (done) begin seen = 1; break; end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_nacc(input int target, input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (nacc >= target) begin ok = 1; break; end
    end
    chk("nacc_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_pending(input int idx, input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (sif.out_valid && sif.out_idx == 4'(idx)) begin ok = 1; break; end
    end
    chk("pending_timeout", 32'(ok), 32'd1);
  endtask

  task automatic end_of_dump(input string name, input int base_done, input int exp_done);
    cyc(3);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done_count"}, 32'(done_cnt - base_done), 32'(exp_done));
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_sel"}, 32'(selDbg), 32'd0);
    chk({name, "_valid"}, 32'(sif.out_valid), 32'd0);
    chk({name, "_data"}, 32'(sif.out_data), 32'd0);
    chk({name, "_idx"}, 32'(sif.out_idx), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base, n, first_valid, viol;
    rst = 1'b1; start = 1'b0; abort = 1'b0; halted = 1'b1;
    we = 1'b0; wsel = '0; wdata = '0;
    cyc(2);
    rst = 1'b0;
    check_zero_outputs("reset");

    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wsel = 4'(i); wdata = 16'h0100 + 16'(i);
      cyc(1);
    end
    we = 1'b0;

    // 1: basic dump with latency measurement
    base = done_cnt; nacc = 0;
    push_seq(0, 15);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; first_valid = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); n++; #1;
      if (sif.out_valid && first_valid < 0) first_valid = n;
      if (done) break;
    end
    chk("first_valid_edge", 32'(first_valid), 32'd2);
    chk("done_edge", 32'(n), 32'd34);
    chk("busy_at_done", 32'(busy), 32'd0);
    cyc(1);
    chk("done_one_cycle", 32'(done), 32'd0);
    end_of_dump("basic", base, 1);

    // 2: backpressure
    base = done_cnt; bp_cnt = 0; bp_mode = 1'b1;
    push_seq(0, 15);
    pulse_start();
    wait_done("bp_done", 300);
    bp_mode = 1'b0;
    end_of_dump("bp", base, 1);

    // 3: halt gating
    base = done_cnt; nacc = 0; halted = 1'b0;
    push_seq(0, 15);
    pulse_start();
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (sif.out_valid) viol++;
      cyc(1);
    end
    chk("no_valid_unhalted", 32'(viol), 32'd0);
    halted = 1'b1;
    wait_nacc(8, 100);
    halted = 1'b0;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (sif.out_valid) viol++;
    end
    chk("no_valid_halt_drop", 32'(viol), 32'd0);
    chk("nacc_during_drop", 32'(nacc), 32'd8);
    halted = 1'b1;
    wait_done("halt_done", 200);
    end_of_dump("halt", base, 1);

    // 4: abort while reg 5 pending with ready high
    base = done_cnt;
    push_seq(0, 4);
    pulse_start();
    wait_pending(5, 100);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_valid", 32'(sif.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    end_of_dump("abort", base, 0);
    base = done_cnt;
    push_seq(0, 15);
    pulse_start();
    wait_done("post_abort_done", 200);
    end_of_dump("post_abort", base, 1);

    // 5: reset while reg 10 pending
    base = done_cnt;
    push_seq(0, 9);
    pulse_start();
    wait_pending(10, 100);
    ready_lvl = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_zero_outputs("midreset");
    ready_lvl = 1'b1;
    end_of_dump("midreset", base, 0);
    base = done_cnt;
    push_seq(0, 15);
    pulse_start();
    wait_done("post_reset_done", 200);
    end_of_dump("post_reset", base, 1);

    // 6: spurious start mid dump
    base = done_cnt; nacc = 0;
    push_seq(0, 15);
    pulse_start();
    wait_nacc(4, 100);
    pulse_start();
    wait_done("spurious_done", 200);
    end_of_dump("spurious", base, 1);
    chk("spurious_words", 32'(nacc), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
